// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-port ALU request arbiter: funct codes, FSM state type
// and the legal-op helper used when ALU_ILLEGAL_OP_EN is defined.
package alu_req_arbiter_pkg;

    localparam int ALU_W = 32;
    localparam int OP_W  = 6;

    localparam logic [OP_W-1:0] FUNCT_ADD = 6'd32;
    localparam logic [OP_W-1:0] FUNCT_SUB = 6'd34;
    localparam logic [OP_W-1:0] FUNCT_AND = 6'd36;
    localparam logic [OP_W-1:0] FUNCT_OR  = 6'd37;
    localparam logic [OP_W-1:0] FUNCT_SLT = 6'd42;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op == FUNCT_ADD) || (op == FUNCT_SUB) || (op == FUNCT_AND) ||
               (op == FUNCT_OR)  || (op == FUNCT_SLT);
    endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Request/response bundle between two requesters, the arbiter and the result consumer.
// The arbiter connects through the slave modport; the environment drives the master side.
interface alu_req_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [5:0]        req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [5:0]        req1_op;

    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_id;
    logic              resp_err;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  resp_valid, resp_data, resp_id, resp_err,
        output resp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output resp_valid, resp_data, resp_id, resp_err,
        input  resp_ready
    );

endinterface

// File: rtl/alu_req_arbiter_alu.sv
// Combinational 32-bit ALU (ADD/SUB/AND/OR/signed SLT); unknown funct codes yield 0.
module alu_req_arbiter_alu
    import alu_req_arbiter_pkg::*;
(
    input  logic             rst_i,
    input  logic [OP_W-1:0]  op_i,
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    output logic [ALU_W-1:0] result_o
);

    always_comb begin
        result_o = '0;
        if (!rst_i) begin
            case (op_i)
                FUNCT_ADD: result_o = a_i + b_i;
                FUNCT_SUB: result_o = a_i - b_i;
                FUNCT_AND: result_o = a_i & b_i;
                FUNCT_OR:  result_o = a_i | b_i;
                FUNCT_SLT: result_o = {{(ALU_W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
                default:   result_o = '0;
            endcase
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters, one operation in flight.
// Optional macro ALU_ILLEGAL_OP_EN: unknown funct codes bypass the ALU and flag resp_err.
module alu_req_arbiter
    import alu_req_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_req_arbiter_if.slave  bus
);

    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [DATA_W-1:0] req_a  [2];
    logic [DATA_W-1:0] req_b  [2];
    logic [OP_W-1:0]   req_op [2];

    assign req_valid = {bus.req1_valid, bus.req0_valid};
    assign req_a[0]  = bus.req0_a;
    assign req_a[1]  = bus.req1_a;
    assign req_b[0]  = bus.req0_b;
    assign req_b[1]  = bus.req1_b;
    assign req_op[0] = bus.req0_op;
    assign req_op[1] = bus.req1_op;

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              id_q, id_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic [ALU_W-1:0]  alu_result;
    logic              grant;
    logic              accept;

    // On a tie the requester that did not win last time gets the ALU.
    assign grant  = (req_valid[0] && req_valid[1]) ? ~last_q : req_valid[1];
    assign accept = |req_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_ready
            assign req_ready[gi] = ~reset && (state_q == ST_IDLE) && req_valid[gi] &&
                                   (grant == 1'(gi));
        end
    endgenerate

    alu_req_arbiter_alu u_alu (
        .rst_i    (1'b0),
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result)
    );

`ifdef ALU_ILLEGAL_OP_EN
    logic illegal_q, illegal_d;
    logic resp_err_q, resp_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        a_d          = a_q;
        b_d          = b_q;
        op_d         = op_q;
        id_d         = id_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
`ifdef ALU_ILLEGAL_OP_EN
        illegal_d    = illegal_q;
        resp_err_d   = resp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = req_a[grant];
                    b_d     = req_b[grant];
                    op_d    = req_op[grant];
                    id_d    = grant;
                    last_d  = grant;
                    state_d = ST_EXEC;
`ifdef ALU_ILLEGAL_OP_EN
                    illegal_d = ~is_legal_op(req_op[grant]);
`endif
                end
            end
            ST_EXEC: begin
                resp_valid_d = 1'b1;
                state_d      = ST_RESP;
`ifdef ALU_ILLEGAL_OP_EN
                resp_data_d  = illegal_q ? '0 : alu_result;
                resp_err_d   = illegal_q;
`else
                resp_data_d  = alu_result;
`endif
            end
            ST_RESP: begin
                // Release returns to IDLE; the next accept is a cycle later.
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_q       <= 1'b1;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            id_q         <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
`ifdef ALU_ILLEGAL_OP_EN
            illegal_q    <= 1'b0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            a_q          <= a_d;
            b_q          <= b_d;
            op_q         <= op_d;
            id_q         <= id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
`ifdef ALU_ILLEGAL_OP_EN
            illegal_q    <= illegal_d;
            resp_err_q   <= resp_err_d;
`endif
        end
    end

    assign bus.req0_ready = req_ready[0];
    assign bus.req1_ready = req_ready[1];
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    // id only changes on accept, so it is already stable for the whole response.
    assign bus.resp_id    = id_q;
`ifdef ALU_ILLEGAL_OP_EN
    assign bus.resp_err   = resp_err_q;
`else
    assign bus.resp_err   = 1'b0;
`endif

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; SHALL equal 32 (the ALU is fixed 32-bit).
REQ-002 Ports SHALL be:
 clk  in  1  single clock, all state on rising edge
 reset  in  1  synchronous, active-high reset
 req0_valid  in  1  requester 0 has an operation
 req0_ready  out  1  requester 0 operation accepted this cycle
 req0_a / req0_b  in  32  requester 0 operands
 req0_op  in  6  requester 0 funct code
 req1_valid, req1_ready, req1_a, req1_b, req1_op  as requester 0, for requester 1
 resp_valid  out  1  result available
 resp_ready  in  1  consumer accepts result
 resp_data  out  32  ALU result
 resp_id  out  1  requester that issued the result
 resp_err  out  1  illegal funct code flag (REQ-016)

Function
REQ-003 The block SHALL share one internal ALU between two requesters, one operation in flight.
REQ-004 States: IDLE, EXEC, RESP.
REQ-005 IDLE: reqN_ready = 1 only for the granted requester with reqN_valid = 1; the other ready = 0.
REQ-006 Grant: one valid -> that one; both valid -> the requester not granted last (round-robin).
REQ-007 Accept (valid & ready) in IDLE: latch a, b, op, id; next state EXEC.
REQ-008 EXEC: drive latched operands/op to the ALU; capture ALU out into resp_data; resp_valid = 1 next cycle; next state RESP.
REQ-009 RESP: resp_data, resp_id, resp_err SHALL hold stable while resp_valid = 1 and resp_ready = 0.
REQ-010 RESP with resp_ready = 1: resp_valid = 0 next cycle; next state IDLE; no accept in the same cycle.
REQ-011 Latency: accept at cycle N -> resp_valid = 1 at cycle N+2; minimum issue interval 3 cycles.
REQ-012 reqN_ready SHALL be 0 in EXEC and RESP regardless of reqN_valid.
REQ-013 The last-grant pointer SHALL update only on accept.
REQ-014 Operands and result pass unmodified; width 32, no extension or truncation.

Reset
REQ-015 While reset = 1 at a clock edge: state IDLE, resp_valid 0, resp_data 0, resp_id 0, resp_err 0, last-grant = 1 (requester 0 wins first tie). reqN_ready = 0 while reset = 1. An in-flight operation is dropped with no response. The internal ALU reset input SHALL be tied 0.

Configuration
REQ-016 Macro ALU_ILLEGAL_OP_EN defined: on accept, op outside {ADD 32, SUB 34, AND 36, OR 37, SLT 42} skips the ALU; response: resp_data = 0, resp_err = 1, same latency.
REQ-017 Macro ALU_ILLEGAL_OP_EN undefined: every op goes to the ALU unchecked; resp_err is tied 0.

Structure
REQ-018 Shared package SHALL hold the funct code constants (ADD, SUB, AND, OR, SLT) and the state enum typedef.
REQ-019 Single sub-module: the existing ALU, instantiated once; round-robin logic stays inline.

Verification
REQ-020 After reset, req0 ADD a = 5, b = 7 -> req0_ready at accept cycle N; resp_valid at N+2, data 12, id 0.
REQ-021 req0 and req1 valid together after reset: req0 SUB 10 - 3 first, then req1 AND 0xF0 & 0x3C -> 7 (id 0), then 0x30 (id 1).
REQ-022 resp_ready held 0 for 4 cycles: resp_data/resp_id stable, both readies 0; release -> IDLE next cycle.
REQ-023 reset asserted during EXEC: next cycle resp_valid 0, state IDLE, no response for the dropped op.
REQ-024 With ALU_ILLEGAL_OP_EN, req1 op 0 -> resp_err 1, data 0, id 1 at N+2. Without the macro, resp_err stays 0.
REQ-025 Continuous requests on both ports: grants alternate 0, 1, 0, 1 across 4 operations.
